// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath types and mode encodings for the ShiftRows pipeline
package aes_pkg;
   localparam int AES_STATE_W = 128;
   typedef logic [AES_STATE_W-1:0] state_t;
   typedef enum logic [1:0] {
      MODE_FWD = 2'b00,
      MODE_INV = 2'b01,
      MODE_BYP = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;
endpackage

// File: rtl/shift_rows.sv
// shift_rows: combinational AES ShiftRows on one state; INVERSE=1 gives InvShiftRows
module shift_rows
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  state_t d_in,
   output state_t d_out
);
   // byte i sits at row i%4, column i/4; each row rotates by its row index
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int ROW = i % 4;
      localparam int SRC = ROW + 4 * (INVERSE ? (i / 4 - ROW + 4) % 4 : (i / 4 + ROW) % 4);
      assign d_out[127-8*i -: 8] = d_in[127-8*SRC -: 8];
   end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: elastic pipeline applying AES (Inv)ShiftRows to LANES states per beat
// Defining SHIFT_ROWS_PIPE_STATS_EN adds beat_count, a wrapping count of output transfers.
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int LANES      = 1,
   parameter int PIPE_DEPTH = 2,
   parameter int TAG_W      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_mode,
   input  logic [TAG_W-1:0]             in_tag,
   input  logic [AES_STATE_W*LANES-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [TAG_W-1:0]             out_tag,
   output logic [AES_STATE_W*LANES-1:0] out_data,
   output logic                         out_err,
   output logic                         busy
`ifdef SHIFT_ROWS_PIPE_STATS_EN
   ,
   output logic [31:0]                  beat_count
`endif
);
   localparam int DW = AES_STATE_W * LANES;
   typedef struct packed {
      logic             err;
      logic [TAG_W-1:0] tag;
      logic [DW-1:0]    data;
   } beat_t;
   mode_e mode;
   logic [DW-1:0] perm;
   logic [PIPE_DEPTH-1:0] v, pv, rdy;
   logic acc;
   beat_t src [PIPE_DEPTH];
   beat_t st [PIPE_DEPTH];
   assign mode = mode_e'(in_mode);
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      state_t fwd, inv;
      shift_rows #(.INVERSE(1'b0)) u_fwd (.d_in(in_data[AES_STATE_W*l +: AES_STATE_W]), .d_out(fwd));
      shift_rows #(.INVERSE(1'b1)) u_inv (.d_in(in_data[AES_STATE_W*l +: AES_STATE_W]), .d_out(inv));
      assign perm[AES_STATE_W*l +: AES_STATE_W] = mode == MODE_FWD ? fwd :
                                                  mode == MODE_INV ? inv :
                                                  in_data[AES_STATE_W*l +: AES_STATE_W];
   end
   // a stage may load when it, or any stage below it, is empty, or the sink takes a beat
   always_comb begin
      acc = out_ready;
      rdy = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         acc = acc | ~v[k];
         rdy[k] = acc;
      end
   end
   always_comb begin
      src[0] = '{err: mode == MODE_RSV, tag: in_tag, data: perm};
      for (int k = 1; k < PIPE_DEPTH; k++) src[k] = st[k-1];
   end
   assign pv = PIPE_DEPTH'({v, in_valid});
   always_ff @(posedge clk)
      if (!rst_n) begin
         v <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) st[k] <= '0;
      end else
         for (int k = 0; k < PIPE_DEPTH; k++)
            if (rdy[k]) begin
               v[k] <= pv[k];
               if (pv[k]) st[k] <= src[k];
            end
   assign in_ready  = rst_n & rdy[0];
   assign out_valid = v[PIPE_DEPTH-1];
   assign out_data  = st[PIPE_DEPTH-1].data;
   assign out_tag   = st[PIPE_DEPTH-1].tag;
   assign out_err   = st[PIPE_DEPTH-1].err;
   assign busy      = |v;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
   always_ff @(posedge clk)
      if (!rst_n) beat_count <= '0;
      else if (out_valid && out_ready) beat_count <= beat_count + 32'd1;
`endif
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed and randomized self-checking bench for shift_rows_pipe
module tb_shift_rows_pipe;
   localparam int D = 2;
   localparam logic [127:0] K  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] F  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] P  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PF = 128'h00050a0f04090e03080d02070c01060b;
   localparam logic [127:0] PI = 128'h000d0a0704010e0b0805020f0c090603;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid, in_ready, out_valid, out_ready, out_err, busy;
   logic [1:0] in_mode;
   logic [3:0] in_tag, out_tag;
   logic [127:0] in_data, out_data;
   logic in_valid2, in_ready2, out_valid2, out_err2, busy2;
   logic [3:0] out_tag2;
   logic [255:0] in_data2, out_data2;
`ifdef SHIFT_ROWS_PIPE_STATS_EN
   logic [31:0] beat_count, beat_count2;
`endif
   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   int tx, rx, sent, got;
   logic took, gave, seen;
   logic [1:0] m;
   logic [127:0] q, x, y;
   logic [132:0] exp_beat;
   logic [132:0] sb [$];

   always #5 clk = ~clk;

   shift_rows_pipe #(.LANES(1), .PIPE_DEPTH(D), .TAG_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_tag(in_tag), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .out_data(out_data), .out_err(out_err), .busy(busy)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
      , .beat_count(beat_count)
`endif
   );

   shift_rows_pipe #(.LANES(2), .PIPE_DEPTH(D), .TAG_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_mode(in_mode),
      .in_tag(in_tag), .in_data(in_data2), .out_valid(out_valid2), .out_ready(1'b1),
      .out_tag(out_tag2), .out_data(out_data2), .out_err(out_err2), .busy(busy2)
`ifdef SHIFT_ROWS_PIPE_STATS_EN
      , .beat_count(beat_count2)
`endif
   );

   always @(posedge clk)
      if (!rst_n) n_out <= 0;
      else if (out_valid && out_ready) n_out <= n_out + 1;

   task automatic check(input string nm, input logic [255:0] got_v, input logic [255:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got_v, exp_v);
      end
   endtask

   // reference ShiftRows written straight from the row/column rotation rule
   function automatic logic [127:0] sr_model(input logic [1:0] md, input logic [127:0] d);
      logic [127:0] r_q;
      int s;
      r_q = d;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            s = md == 2'd0 ? (c + r) % 4 : md == 2'd1 ? (c + 4 - r) % 4 : c;
            r_q[127-8*(r+4*c) -: 8] = d[127-8*(r+4*s) -: 8];
         end
      return r_q;
   endfunction

   task automatic run(input string nm, input logic [1:0] md, input logic [3:0] t,
                      input logic [127:0] d, output logic [127:0] r_q);
      @(negedge clk);
      check({nm, "_rdy"}, in_ready, 1);
      in_valid = 1'b1; in_mode = md; in_tag = t; in_data = d;
      for (int c = 1; c < D; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check({nm, "_lat"}, out_valid, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check({nm, "_vld"}, out_valid, 1);
      check({nm, "_tag"}, out_tag, t);
      check({nm, "_err"}, out_err, md == 2'b11);
      r_q = out_data;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      in_valid = 0; in_mode = 0; in_tag = 0; in_data = 0; out_ready = 1;
      in_valid2 = 0; in_data2 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vld", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", out_err, 0);
      check("rst_data", out_data, 0);
      check("rst_tag", out_tag, 0);
      check("rst_rdy", in_ready, 0);
      check("rst_vld2", out_valid2, 0);
      rst_n = 1'b1;
      #1 check("rel_rdy", in_ready, 1);
      // directed single beats with hand-computed results
      run("fwd", 2'd0, 4'd3, K, q); check("fwd_data", q, F);
      run("inv", 2'd1, 4'd5, F, q); check("inv_data", q, K);
      run("byp", 2'd2, 4'd7, F, q); check("byp_data", q, F);
      run("rsv", 2'd3, 4'd9, F, q); check("rsv_data", q, F);
      run("fwd_seq", 2'd0, 4'd1, P, q); check("fwd_seq_data", q, PF);
      run("inv_seq", 2'd1, 4'd2, P, q); check("inv_seq_data", q, PI);
      for (int j = 0; j < 3; j++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         run("rt_f", 2'd0, 4'(j), x, y); check("rt_fwd", y, sr_model(2'd0, x));
         run("rt_i", 2'd1, 4'(j), y, q); check("rt_back", q, x);
      end
      // two lanes: lane 1 carries the known vector, lane 0 stays zero
      @(negedge clk);
      check("l2_rdy", in_ready2, 1);
      in_valid2 = 1'b1; in_mode = 2'd0; in_tag = 4'd6; in_data2 = {K, 128'h0};
      @(negedge clk);
      in_valid2 = 1'b0;
      check("l2_lat", out_valid2, 0);
      check("l2_busy", busy2, 1);
      @(negedge clk);
      check("l2_vld", out_valid2, 1);
      check("l2_data", out_data2, {F, 128'h0});
      check("l2_tag", out_tag2, 6);
      check("l2_err", out_err2, 0);
      // sink stalled for 10 cycles while 6 beats are offered
      @(posedge clk); #1;
      tx = 0; rx = 0; out_ready = 0; in_valid = 1; in_mode = 2'd0; in_tag = 0; in_data = P;
      for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         gave = out_valid && out_ready;
         if (cyc == 3 || cyc == 9) begin
            check("stall_acc", tx, 2);
            check("stall_rdy", in_ready, 0);
            check("stall_tag", out_tag, 0);
            check("stall_data", out_data, PF);
         end
         if (gave) begin
            check("stall_otag", out_tag, rx);
            check("stall_odata", out_data, sr_model(2'd0, P ^ 128'(rx)));
         end
         @(posedge clk); #1;
         tx += int'(took); rx += int'(gave);
         in_valid = tx < 6; in_tag = 4'(tx); in_data = P ^ 128'(tx);
         out_ready = cyc >= 9;
      end
      in_valid = 0;
      check("stall_cnt", rx, 6);
      // reset with two beats in flight
      @(posedge clk); #1;
      out_ready = 0; in_valid = 1; in_mode = 2'd1; in_tag = 4'hc; in_data = K;
      @(posedge clk);
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      check("fly_busy", busy, 1);
      check("fly_vld", out_valid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_vld", out_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_rdy", in_ready, 0);
      check("mrst_data", out_data, 0);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
      check("mrst_cnt", beat_count, 0);
`endif
      rst_n = 1'b1; out_ready = 1; seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("mrst_stale", seen, 0);
      // random handshakes with mixed modes against a scoreboard
      @(posedge clk); #1;
      sent = 0; got = 0; took = 1; in_valid = 0;
      for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
         if (took || !in_valid) begin
            m = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom, $urandom, $urandom};
            in_mode = m; in_tag = 4'(sent); in_data = x;
            in_valid = sent < 1000 && $urandom_range(0, 1) == 1;
         end
         out_ready = $urandom_range(0, 1) == 1;
         @(negedge clk);
         took = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("rnd_extra", sb.size(), 1);
            else begin
               exp_beat = sb.pop_front();
               check("rnd_beat", {out_err, out_tag, out_data}, exp_beat);
            end
            got++;
         end
         if (took) begin
            sb.push_back({m == 2'b11, 4'(sent), sr_model(m, x)});
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 0;
      check("rnd_sent", sent, 1000);
      check("rnd_got", got, 1000);
`ifdef SHIFT_ROWS_PIPE_STATS_EN
      @(negedge clk);
      check("stat_cnt", beat_count, n_out);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving the number of independent 128-bit AES states carried per beat (1..4).
REQ-002 The block SHALL have parameter PIPE_DEPTH, default 2, giving the number of register stages (1..4).
REQ-003 The block SHALL have parameter TAG_W, default 4, giving the width of the sideband tag carried with each beat (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: a synchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-008 The block SHALL have port in_mode, input, 2 bits, with encodings 00 forward ShiftRows, 01 inverse ShiftRows, 10 bypass, 11 reserved.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits: opaque sideband.
REQ-010 The block SHALL have port in_data, input, 128*LANES bits: lane L occupies bits [128L+127:128L].
REQ-011 The block SHALL have port out_valid, output, 1 bit.
REQ-012 The block SHALL have port out_ready, input, 1 bit.
REQ-013 The block SHALL have ports out_tag (TAG_W bits) and out_data (128*LANES bits), both outputs.
REQ-014 The block SHALL have port out_err, output, 1 bit: the beat was issued with the reserved mode.
REQ-015 The block SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid beat.

Function
REQ-016 Each lane SHALL use this byte map: byte i is bits [127-8i:120-8i] of the lane, with row r = i mod 4 and column c = i div 4.
REQ-017 Forward mode SHALL compute out[r,c] = in[r,(c+r) mod 4]; inverse mode SHALL compute out[r,c] = in[r,(c-r) mod 4]; bypass and reserved modes SHALL pass the lane through unchanged.
REQ-018 The permutation SHALL be applied combinationally ahead of stage 0 to all lanes with the same mode; each stage SHALL register data, tag, err and valid.
REQ-019 A beat SHALL transfer on any interface when valid and ready are both high on the same rising clk edge.
REQ-020 Stage k SHALL be ready when it is empty or when stage k+1 is ready; the ready of the last stage SHALL be out_ready, and in_ready SHALL equal stage 0 ready.
REQ-021 in_ready SHALL depend only on registered state and out_ready, with no combinational path from in_valid.
REQ-022 With out_ready held high, latency SHALL be exactly PIPE_DEPTH cycles from input transfer to out_valid, and throughput SHALL be one beat per cycle.
REQ-023 When out_valid=1 and out_ready=0, out_data, out_tag and out_err SHALL remain stable until the beat transfers.
REQ-024 Beats SHALL never be dropped, duplicated or reordered; when the pipeline is full and out_ready=0, in_ready SHALL be 0.
REQ-025 In a cycle where the last stage transfers out, the pipeline SHALL accept a new input in the same cycle, so a full pipeline with out_ready=1 keeps in_ready=1.
REQ-026 out_err SHALL be 1 only for beats issued with in_mode=11.

Reset
REQ-027 When rst_n=0 at a clk edge, all stage valid bits SHALL clear, giving out_valid=0, busy=0 and out_err=0.
REQ-028 out_data and out_tag SHALL read zero after reset.
REQ-029 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 in the first cycle after reset release.
REQ-030 A reset asserted mid-stream SHALL discard all in-flight beats.

Configuration
REQ-031 With SHIFT_ROWS_PIPE_STATS_EN defined, the block SHALL add output beat_count [31:0], which counts output transfers, wraps from FFFFFFFF to 0, and clears on reset.
REQ-032 Without SHIFT_ROWS_PIPE_STATS_EN, the beat_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package aes_pkg SHALL hold the mode enum (MODE_FWD, MODE_INV, MODE_BYP, MODE_RSV), the AES_STATE_W=128 constant, and a state_t typedef.
REQ-034 The per-lane permutation SHALL be the existing combinational sub-module shift_rows, instantiated once per lane per direction, with INVERSE=0 and INVERSE=1, and muxed by mode.

Verification
REQ-035 Bench scenario: forward mode, LANES=1, input d42711aee0bf98f1b8b45de51e415230 -> output d4bf5d30e0b452aeb84111f11e2798e5 after PIPE_DEPTH cycles, with the tag echoed.
REQ-036 Bench scenario: inverse mode, input d4bf5d30e0b452aeb84111f11e2798e5 -> output d42711aee0bf98f1b8b45de51e415230; bypass of the same input -> unchanged; mode 11 -> unchanged with out_err=1.
REQ-037 Bench scenario: LANES=2, with lane 1 the known vector and lane 0 zeros, forward -> lane 1 permuted and lane 0 zero.
REQ-038 Bench scenario: out_ready=0 for 10 cycles while 6 beats are offered (PIPE_DEPTH=2) -> exactly 2 accepted, out_data stable, then 6 delivered in order with tags 0..5.
REQ-039 Bench scenario: random in_valid/out_ready at 50% over 1000 beats with mixed modes -> a scoreboard matches every beat, with a forward-then-inverse round trip returning the original value.
REQ-040 Bench scenario: rst_n asserted with 2 beats in flight -> out_valid=0 and busy=0 next cycle, and no stale beat emerges; with SHIFT_ROWS_PIPE_STATS_EN, beat_count reads 0.
